// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA wishbone arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> DONE -> IDLE)
//   chid_w(n)   : width of a channel index for n channels (at least 1 bit)
package dma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    function automatic int chid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin picker.
// Finds the first asserted request at or after i_ptr, searching upward and
// wrapping from N_CH-1 back to 0.
//   i_req   : per-channel request vector
//   i_ptr   : channel with highest priority this cycle (must be < N_CH)
//   o_valid : at least one request is asserted
//   o_idx   : index of the selected channel (0 when o_valid is low)
module dma_rr_picker
    import dma_arb_pkg::*;
#(
    parameter int   N_CH   = 2,
    localparam int  CHID_W = chid_w(N_CH)
) (
    input  logic [N_CH-1:0]   i_req,
    input  logic [CHID_W-1:0] i_ptr,
    output logic              o_valid,
    output logic [CHID_W-1:0] o_idx
);

    // w_cand[k] is the channel sitting k places after the pointer.
    logic [CHID_W-1:0] w_cand [N_CH];
    logic [N_CH-1:0]   w_hit;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
            // One spare bit so ptr + offset cannot overflow before the wrap.
            logic [CHID_W:0] w_sum;
            assign w_sum        = {1'b0, i_ptr} + (CHID_W+1)'(gi);
            assign w_cand[gi]   = (w_sum >= (CHID_W+1)'(N_CH))
                                ? CHID_W'(w_sum - (CHID_W+1)'(N_CH))
                                : CHID_W'(w_sum);
            assign w_hit[gi]    = i_req[w_cand[gi]];
        end
    endgenerate

    assign o_valid = |w_hit;

    // Scan from the far end so the nearest hit to the pointer wins.
    always_comb begin
        o_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/dma_wb_arbiter.sv
// Round-robin scheduler sharing one wishbone master agent among N_CH DMA
// channel FSMs, with lock support so a channel can keep a read->write pair
// together.
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_req/i_lock/i_we         : per-channel request, keep-grant, write enable
//   i_addr/i_wdata            : per-channel command, channel n in slice n
//   o_ack, o_rdata            : completion pulse to granted channel, read data
//   o_busy, o_grant_id        : arbiter not idle, current/last granted channel
//   o_agt_start/we/addr/wdata : command to the agent (start is a 1-cycle pulse)
//   i_agt_done, i_agt_rdata   : agent completion pulse and read data
module dma_wb_arbiter
    import dma_arb_pkg::*;
#(
    parameter int   N_CH       = 2,
    parameter int   DATA_WIDTH = 32,
    parameter int   ADDR_WIDTH = 32,
    localparam int  CHID_W     = chid_w(N_CH)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_CH-1:0]            i_req,
    input  logic [N_CH-1:0]            i_lock,
    input  logic [N_CH-1:0]            i_we,
    input  logic [N_CH*ADDR_WIDTH-1:0] i_addr,
    input  logic [N_CH*DATA_WIDTH-1:0] i_wdata,
    output logic [N_CH-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]      o_rdata,
    output logic                       o_busy,
    output logic [CHID_W-1:0]          o_grant_id,
    output logic                       o_agt_start,
    output logic                       o_agt_we,
    output logic [ADDR_WIDTH-1:0]      o_agt_addr,
    output logic [DATA_WIDTH-1:0]      o_agt_wdata,
    input  logic                       i_agt_done,
    input  logic [DATA_WIDTH-1:0]      i_agt_rdata
);

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic [CHID_W-1:0]       r_gid;
    logic [CHID_W-1:0]       r_ptr;
    logic                    r_lock_own;
    logic                    r_lock;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [N_CH-1:0]         r_ack;

    logic [ADDR_WIDTH-1:0]   w_addr_ch  [N_CH];
    logic [DATA_WIDTH-1:0]   w_wdata_ch [N_CH];
    logic [CHID_W-1:0]       w_gid_inc;
    logic                    w_lock_hold;
    logic                    w_lock_drop;
    logic [CHID_W-1:0]       w_search_ptr;
    logic                    w_pick_valid;
    logic [CHID_W-1:0]       w_pick_idx;
    logic                    w_grant;
    logic [CHID_W-1:0]       w_grant_id;
    logic                    w_start;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_slice
            assign w_addr_ch[gi]  = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_ch[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_gid_inc   = (r_gid == CHID_W'(N_CH - 1)) ? '0 : r_gid + 1'b1;
    assign w_lock_hold = r_lock_own &&  i_req[r_gid];
    assign w_lock_drop = r_lock_own && !i_req[r_gid];

    // A locker that lets go hands priority to its neighbour in the same
    // cycle, so the search already starts from gid+1.
    assign w_search_ptr = w_lock_drop ? w_gid_inc : r_ptr;

    dma_rr_picker #(
        .N_CH (N_CH)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (w_search_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_grant    = w_lock_hold || w_pick_valid;
    assign w_grant_id = w_lock_hold ? r_gid : w_pick_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = ISSUE;
            ISSUE: begin
                w_start      = 1'b1;
                w_state_next = WAIT;
            end
            WAIT:    if (i_agt_done) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gid      <= '0;
            r_ptr      <= '0;
            r_lock_own <= 1'b0;
            r_lock     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ack      <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_lock_drop) begin
                        r_lock_own <= 1'b0;
                        r_ptr      <= w_gid_inc;
                    end
                    if (w_grant) begin
                        r_gid   <= w_grant_id;
                        r_we    <= i_we[w_grant_id];
                        r_lock  <= i_lock[w_grant_id];
                        r_addr  <= w_addr_ch[w_grant_id];
                        r_wdata <= w_wdata_ch[w_grant_id];
                    end
                end
                WAIT: begin
                    if (i_agt_done) begin
                        // Writes report zero so a channel never sees bus junk.
                        r_rdata      <= r_we ? '0 : i_agt_rdata;
                        r_ack[r_gid] <= 1'b1;
                    end
                end
                DONE: begin
                    r_lock_own <= r_lock;
                    if (!r_lock) begin
                        r_ptr <= w_gid_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_rdata     = r_rdata;
    assign o_busy      = (r_state != IDLE);
    assign o_grant_id  = r_gid;
    assign o_agt_start = w_start;
    assign o_agt_we    = r_we;
    assign o_agt_addr  = r_addr;
    assign o_agt_wdata = r_wdata;

endmodule

// File: tb/tb_dma_wb_arbiter.sv
// Scoreboard bench for dma_wb_arbiter: a 3-channel instance for directed
// transfers, lock, wrap, stale-done and reset cases, plus a 2-channel
// instance for the fairness sequence.
module tb_dma_wb_arbiter;

    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- 3-channel DUT ----------------
    logic [NC-1:0]    req = '0;
    logic [NC-1:0]    lock = '0;
    logic [NC-1:0]    we = '0;
    logic [NC*32-1:0] addr = '0;
    logic [NC*32-1:0] wdata = '0;
    logic [NC-1:0]    ack;
    logic [31:0]      rdata;
    logic             busy;
    logic [1:0]       gid;
    logic             agt_start;
    logic             agt_we;
    logic [31:0]      agt_addr;
    logic [31:0]      agt_wdata;
    logic             agt_done = 1'b0;
    logic             stale_done = 1'b0;
    logic [31:0]      agt_rdata = '0;
    logic             done_in;
    assign done_in = agt_done | stale_done;

    dma_wb_arbiter #(.N_CH(NC), .DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata),
        .o_busy(busy), .o_grant_id(gid), .o_agt_start(agt_start),
        .o_agt_we(agt_we), .o_agt_addr(agt_addr), .o_agt_wdata(agt_wdata),
        .i_agt_done(done_in), .i_agt_rdata(agt_rdata)
    );

    // ---------------- 2-channel DUT (fairness) ----------------
    logic [1:0]  req2;
    logic [1:0]  lock2 = '0;
    logic [1:0]  we2 = '0;
    logic [63:0] addr2 = {32'h0000_0014, 32'h0000_0010};
    logic [63:0] wdata2 = '0;
    logic [1:0]  ack2;
    logic [31:0] rdata2;
    logic        busy2;
    logic [0:0]  gid2;
    logic        start2;
    logic        agt_we2;
    logic [31:0] agt_addr2;
    logic [31:0] agt_wdata2;
    logic        done2 = 1'b0;
    logic [31:0] agt_rdata2 = '0;

    dma_wb_arbiter #(.N_CH(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_req(req2), .i_lock(lock2), .i_we(we2),
        .i_addr(addr2), .i_wdata(wdata2), .o_ack(ack2), .o_rdata(rdata2),
        .o_busy(busy2), .o_grant_id(gid2), .o_agt_start(start2),
        .o_agt_we(agt_we2), .o_agt_addr(agt_addr2), .o_agt_wdata(agt_wdata2),
        .i_agt_done(done2), .i_agt_rdata(agt_rdata2)
    );

    // ---------------- channel command tables ----------------
    typedef struct packed {
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t cmds [NC][16];
    int   cnt  [NC];
    int   pos  [NC];

    initial begin
        for (int n = 0; n < NC; n++) begin
            cnt[n] = 0;
            pos[n] = 0;
        end
    end

    task automatic add(input int ch, input logic w, input logic lk,
                       input logic [31:0] a, input logic [31:0] d);
        cmds[ch][cnt[ch]] = '{we: w, lock: lk, addr: a, wdata: d};
        cnt[ch]++;
    endtask

    // Each channel holds req until its ack, then moves to its next command.
    always @(negedge clk) begin
        for (int n = 0; n < NC; n++) begin
            if (rst) pos[n] = cnt[n];
            else if (ack[n] && pos[n] < cnt[n]) pos[n] = pos[n] + 1;
            if (!rst && pos[n] < cnt[n]) begin
                req[n]            = 1'b1;
                we[n]             = cmds[n][pos[n]].we;
                lock[n]           = cmds[n][pos[n]].lock;
                addr[n*32 +: 32]  = cmds[n][pos[n]].addr;
                wdata[n*32 +: 32] = cmds[n][pos[n]].wdata;
            end else begin
                req[n]  = 1'b0;
                we[n]   = 1'b0;
                lock[n] = 1'b0;
            end
        end
    end

    // ---------------- agent models ----------------
    int agt_lat = 2;

    always begin : agent3
        logic        we_c;
        logic [31:0] a_c;
        logic        aborted;
        @(negedge clk);
        if (agt_start && !rst) begin
            we_c    = agt_we;
            a_c     = agt_addr;
            aborted = 1'b0;
            for (int i = 0; i < agt_lat; i++) begin
                @(posedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                #1;
                agt_done  = 1'b1;
                agt_rdata = we_c ? 32'hBAD0_BAD0 : ((a_c == 32'h100) ? 32'hDEAD_BEEF : ~a_c);
                @(posedge clk);
                #1;
                agt_done  = 1'b0;
                agt_rdata = '0;
            end
        end
    end

    always begin : agent2
        @(negedge clk);
        if (start2 && !rst) begin
            @(posedge clk);
            #1;
            done2      = 1'b1;
            agt_rdata2 = {16'h2000, agt_addr2[15:0]};
            @(posedge clk);
            #1;
            done2      = 1'b0;
            agt_rdata2 = '0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  ch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t start_q[$];
    exp_t ack_q[$];
    int   n_start = 0;
    int   last_start_cyc = 0;
    int   last_ack_cyc = 0;
    int   last_gap = 0;

    task automatic expect_start(input logic [1:0] ch, input logic w,
                                input logic [31:0] a, input logic [31:0] d);
        start_q.push_back('{ch: ch, we: w, addr: a, wdata: d, rdata: 32'h0});
    endtask

    task automatic expect_xfer(input logic [1:0] ch, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] rd);
        start_q.push_back('{ch: ch, we: w, addr: a, wdata: d, rdata: rd});
        ack_q.push_back('{ch: ch, we: w, addr: a, wdata: d, rdata: rd});
    endtask

    always @(negedge clk) begin : monitor3
        exp_t e;
        if (rst) begin
            start_q.delete();
            ack_q.delete();
        end else begin
            if (agt_start) begin
                n_start++;
                last_gap       = cyc - last_ack_cyc;
                last_start_cyc = cyc;
                if (start_q.size() == 0) begin
                    check("unexpected agent start", 32'd1, 32'd0);
                end else begin
                    e = start_q.pop_front();
                    check("start grant_id", {30'b0, gid}, {30'b0, e.ch});
                    check("start agt_we", {31'b0, agt_we}, {31'b0, e.we});
                    check("start agt_addr", agt_addr, e.addr);
                    check("start agt_wdata", agt_wdata, e.wdata);
                end
            end
            if (ack != '0) begin
                last_ack_cyc = cyc;
                if (ack_q.size() == 0) begin
                    check("unexpected ack", {29'b0, ack}, 32'd0);
                end else begin
                    e = ack_q.pop_front();
                    check("ack vector", {29'b0, ack}, 32'd1 << e.ch);
                    check("ack rdata", rdata, e.rdata);
                    check("busy during ack", {31'b0, busy}, 32'd1);
                end
            end
        end
    end

    logic [1:0] fair_q[$];
    logic       fair_on = 1'b0;
    int         fair_cnt = 0;
    assign req2 = (fair_on && fair_cnt < 6) ? 2'b11 : 2'b00;

    always @(negedge clk) begin : monitor2
        logic [1:0] ch;
        if (!rst && ack2 != '0) begin
            if (fair_q.size() == 0) begin
                check("fair unexpected ack", {30'b0, ack2}, 32'd0);
            end else begin
                ch = fair_q.pop_front();
                check("fair ack vector", {30'b0, ack2}, (ch == 2'd1) ? 32'd2 : 32'd1);
                check("fair rdata", rdata2, (ch == 2'd1) ? 32'h2000_0014 : 32'h2000_0010);
            end
            fair_cnt++;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic tables_done();
        for (int n = 0; n < NC; n++) begin
            if (pos[n] < cnt[n]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_quiet(input string name);
        int   k;
        logic pend;
        k    = 0;
        pend = 1'b1;
        while (pend && k < 300) begin
            @(posedge clk);
            #1;
            k++;
            pend = busy || (start_q.size() != 0) || (ack_q.size() != 0) || !tables_done();
        end
        check(name, {31'b0, pend}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " o_ack"}, {29'b0, ack}, 32'd0);
        check({tag, " o_rdata"}, rdata, 32'd0);
        check({tag, " o_busy"}, {31'b0, busy}, 32'd0);
        check({tag, " o_grant_id"}, {30'b0, gid}, 32'd0);
        check({tag, " o_agt_start"}, {31'b0, agt_start}, 32'd0);
        check({tag, " o_agt_we"}, {31'b0, agt_we}, 32'd0);
        check({tag, " o_agt_addr"}, agt_addr, 32'd0);
        check({tag, " o_agt_wdata"}, agt_wdata, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int c0;
        int k;
        int s0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset dut2 busy", {31'b0, busy2}, 32'd0);
        rst = 1'b0;

        // Fairness on the 2-channel instance: both requests held, no lock.
        for (int i = 0; i < 6; i++) fair_q.push_back((i % 2 == 1) ? 2'd1 : 2'd0);
        fair_on = 1'b1;

        // 1) single read, latency
        @(posedge clk);
        #1;
        add(0, 1'b0, 1'b0, 32'h100, 32'h0);
        expect_xfer(2'd0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
        c0 = cyc;
        wait_quiet("t1 completes");
        check("t1 start latency", last_start_cyc, c0 + 1);
        check("t1 ack latency", last_ack_cyc, c0 + 4);
        check("t1 rdata holds", rdata, 32'hDEAD_BEEF);

        // 5) stale done in IDLE
        @(posedge clk);
        #1;
        stale_done = 1'b1;
        @(posedge clk);
        #1;
        stale_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("stale no ack", {29'b0, ack}, 32'd0);
            check("stale stays idle", {31'b0, busy}, 32'd0);
        end
        check("stale rdata unchanged", rdata, 32'hDEAD_BEEF);

        // ch1 alone moves ptr to 2
        add(1, 1'b0, 1'b0, 32'h200, 32'h0);
        expect_xfer(2'd1, 1'b0, 32'h200, 32'h0, 32'hFFFF_FDFF);
        wait_quiet("ch1 single completes");

        // 4) wrap: ptr=2, req=011 -> ch0, then ch1 (write returns 0)
        add(0, 1'b0, 1'b0, 32'h400, 32'h0);
        add(1, 1'b1, 1'b0, 32'h500, 32'h55AA_55AA);
        expect_xfer(2'd0, 1'b0, 32'h400, 32'h0, 32'hFFFF_FBFF);
        expect_xfer(2'd1, 1'b1, 32'h500, 32'h55AA_55AA, 32'h0);
        wait_quiet("t4 wrap completes");
        check("t4 rdata zero after write", rdata, 32'h0);

        // ch2 alone wraps ptr back to 0
        add(2, 1'b0, 1'b0, 32'h300, 32'h0);
        expect_xfer(2'd2, 1'b0, 32'h300, 32'h0, 32'hFFFF_FCFF);
        wait_quiet("ch2 single completes");

        // 3) lock: ch0 read(lock) + write(unlock); ch1, ch2 waiting throughout
        add(0, 1'b0, 1'b1, 32'h600, 32'h0);
        add(0, 1'b1, 1'b0, 32'h604, 32'h1234_5678);
        add(1, 1'b0, 1'b0, 32'h700, 32'h0);
        add(2, 1'b0, 1'b0, 32'h800, 32'h0);
        expect_xfer(2'd0, 1'b0, 32'h600, 32'h0, 32'hFFFF_F9FF);
        expect_xfer(2'd0, 1'b1, 32'h604, 32'h1234_5678, 32'h0);
        expect_xfer(2'd1, 1'b0, 32'h700, 32'h0, 32'hFFFF_F8FF);
        expect_xfer(2'd2, 1'b0, 32'h800, 32'h0, 32'hFFFF_F7FF);
        wait_quiet("t3 lock completes");

        // Locker drops req in IDLE: ch1 granted in that same IDLE cycle
        add(0, 1'b0, 1'b1, 32'hD00, 32'h0);
        add(1, 1'b0, 1'b0, 32'hE00, 32'h0);
        expect_xfer(2'd0, 1'b0, 32'hD00, 32'h0, 32'hFFFF_F2FF);
        expect_xfer(2'd1, 1'b0, 32'hE00, 32'h0, 32'hFFFF_F1FF);
        wait_quiet("lock drop completes");
        check("lock drop regrant gap", last_gap, 2);

        // Fairness run must be finished before the reset test
        k = 0;
        while (fair_cnt < 6 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("fair acks seen", fair_cnt, 6);

        // 6) async reset in WAIT; ptr made nonzero first
        add(0, 1'b0, 1'b0, 32'h900, 32'h0);
        expect_xfer(2'd0, 1'b0, 32'h900, 32'h0, 32'hFFFF_F6FF);
        wait_quiet("pre-reset ch0 completes");
        agt_lat = 6;
        add(1, 1'b0, 1'b0, 32'hA00, 32'h0);
        expect_start(2'd1, 1'b0, 32'hA00, 32'h0);
        s0 = n_start;
        k  = 0;
        while (n_start == s0 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t6 start seen", {31'b0, (n_start != s0)}, 32'd1);
        @(negedge clk);
        #1;
        check("t6 busy in WAIT", {31'b0, busy}, 32'd1);
        check("t6 gid in WAIT", {30'b0, gid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("mid reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        agt_lat = 2;
        @(posedge clk);
        #1;
        check("post reset idle", {31'b0, busy}, 32'd0);
        add(0, 1'b0, 1'b0, 32'hB00, 32'h0);
        add(1, 1'b0, 1'b0, 32'hC00, 32'h0);
        expect_xfer(2'd0, 1'b0, 32'hB00, 32'h0, 32'hFFFF_F4FF);
        expect_xfer(2'd1, 1'b0, 32'hC00, 32'h0, 32'hFFFF_F3FF);
        wait_quiet("post reset completes");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
